// File: rtl/clk_enable_nco.sv
// Multi-channel NCO clock-enable generator: per-channel fractional-rate tick, square wave and lock status.
// Optional macro PHASE_ALIGN_EN adds an align input that restarts every accumulator phase at once.
module clk_enable_nco #(
    parameter int                   ACC_WIDTH   = 16,
    parameter int                   CHANNELS    = 2,
    parameter int                   LOCK_CYCLES = 1024,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 16'h4000
) (
    input  logic                                              clk_36MHz,
    input  logic                                              reset,
    input  logic                                              wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
    input  logic [ACC_WIDTH-1:0]                              wr_inc,
`ifdef PHASE_ALIGN_EN
    input  logic                                              align,
`endif
    output logic [CHANNELS-1:0]                               tick,
    output logic [CHANNELS-1:0]                               clk_out,
    output logic [CHANNELS-1:0]                               locked
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic [ACC_WIDTH-1:0] acc      [CHANNELS];
    logic [ACC_WIDTH-1:0] inc      [CHANNELS];
    logic [ACC_WIDTH:0]   sum      [CHANNELS];
    logic [LOCK_W-1:0]    lock_cnt [CHANNELS];
    logic [CHANNELS-1:0]  sel;
    logic                 align_hit;

    // Out-of-range channel numbers decode to no channel, so such writes vanish.
    always_comb begin
        sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sel[c] = wr_en && (wr_chan == CHAN_W'(c));
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c] = {1'b0, acc[c]} + {1'b0, inc[c]};
        end
    end

    always_comb begin
        align_hit = 1'b0;
`ifdef PHASE_ALIGN_EN
        align_hit = align;
`endif
    end

    always_comb begin
        clk_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            clk_out[c] = acc[c][ACC_WIDTH-1];
        end
    end

    always_ff @(posedge clk_36MHz or posedge reset) begin
        if (reset) begin
            tick   <= '0;
            locked <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]      <= '0;
                inc[c]      <= DEFAULT_INC;
                lock_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sel[c]) begin
                    // A write is a full phase restart, even when the value is unchanged.
                    inc[c]      <= wr_inc;
                    acc[c]      <= '0;
                    tick[c]     <= 1'b0;
                    locked[c]   <= 1'b0;
                    lock_cnt[c] <= '0;
                end else begin
                    if (align_hit) begin
                        acc[c]  <= '0;
                        tick[c] <= 1'b0;
                    end else begin
                        acc[c]  <= sum[c][ACC_WIDTH-1:0];
                        tick[c] <= sum[c][ACC_WIDTH];
                    end
                    // A stopped channel never counts toward lock; the counter holds once locked.
                    if ((inc[c] != '0) && !locked[c]) begin
                        if (lock_cnt[c] == LOCK_LAST) begin
                            locked[c] <= 1'b1;
                        end else begin
                            lock_cnt[c] <= lock_cnt[c] + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_nco.sv
// Directed bench for clk_enable_nco: vector table for the free-running/rewrite patterns plus
// hand-written sequences for lock restart, zero rate, out-of-range writes, async reset and align.
module tb_clk_enable_nco;

    logic        clk_36MHz = 1'b0;
    logic        reset     = 1'b1;
    logic        wr_en     = 1'b0;
    logic [0:0]  wr_chan   = '0;
    logic [15:0] wr_inc    = '0;
    logic [1:0]  tick, clk_out, locked;

    logic        wr_en3    = 1'b0;
    logic [1:0]  wr_chan3  = '0;
    logic [15:0] wr_inc3   = '0;
    logic [2:0]  tick3, clk_out3, locked3;

`ifdef PHASE_ALIGN_EN
    logic        align     = 1'b0;
    logic        align3    = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_36MHz = ~clk_36MHz;

    clk_enable_nco #(.ACC_WIDTH(16), .CHANNELS(2), .LOCK_CYCLES(8), .DEFAULT_INC(16'h4000)) dut (
        .clk_36MHz(clk_36MHz),
        .reset(reset),
        .wr_en(wr_en),
        .wr_chan(wr_chan),
        .wr_inc(wr_inc),
`ifdef PHASE_ALIGN_EN
        .align(align),
`endif
        .tick(tick),
        .clk_out(clk_out),
        .locked(locked)
    );

    clk_enable_nco #(.ACC_WIDTH(16), .CHANNELS(3), .LOCK_CYCLES(8), .DEFAULT_INC(16'h4000)) dut3 (
        .clk_36MHz(clk_36MHz),
        .reset(reset),
        .wr_en(wr_en3),
        .wr_chan(wr_chan3),
        .wr_inc(wr_inc3),
`ifdef PHASE_ALIGN_EN
        .align(align3),
`endif
        .tick(tick3),
        .clk_out(clk_out3),
        .locked(locked3)
    );

    typedef struct {
        logic        wr_en;
        logic        wr_chan;
        logic [15:0] wr_inc;
        logic [1:0]  tick;
        logic [1:0]  clk;
        logic [1:0]  lock;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_36MHz);
        #1;
    endtask

    initial begin
        int bad;
        int nticks;

        // edges 1..8 after reset release at inc=4000; edge 9 rewrites ch0 to 6000
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b00};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b11};
        vecs[8]  = '{1'b1, 1'b0, 16'h6000, 2'b00, 2'b00, 2'b10};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b10, 2'b10};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b10};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b10};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b01, 2'b10};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b10};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 2'b01, 2'b10, 2'b10};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 2'b10, 2'b01, 2'b10};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b11};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b10, 2'b11};

        repeat (2) @(posedge clk_36MHz);
        #1;
        check("reset_tick", {30'd0, tick}, 32'd0);
        check("reset_clk_out", {30'd0, clk_out}, 32'd0);
        check("reset_locked", {30'd0, locked}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_chan = vecs[i].wr_chan;
            wr_inc  = vecs[i].wr_inc;
            step();
            wr_en = 1'b0;
            check($sformatf("vec%0d_tick", i), {30'd0, tick}, {30'd0, vecs[i].tick});
            check($sformatf("vec%0d_clk_out", i), {30'd0, clk_out}, {30'd0, vecs[i].clk});
            check($sformatf("vec%0d_locked", i), {30'd0, locked}, {30'd0, vecs[i].lock});
        end

        // Lock restart: write ch1 on edge 5 of a fresh count
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        wr_en = 1'b1; wr_chan = 1'b1; wr_inc = 16'h4000;
        step();
        wr_en = 1'b0;
        check("relock_after_write", {30'd0, locked}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("relock_edge%0d", i), {30'd0, locked},
                  {30'd0, (i >= 8) ? 1'b1 : 1'b0, (5 + i >= 8) ? 1'b1 : 1'b0});
        end

        // Zero increment on ch1 stops it; ch0 keeps a 1-in-4 tick rate
        wr_en = 1'b1; wr_chan = 1'b1; wr_inc = 16'h0000;
        step();
        wr_en = 1'b0;
        bad = 0;
        nticks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick[1] !== 1'b0 || clk_out[1] !== 1'b0 || locked[1] !== 1'b0) bad++;
            if (tick[0] === 1'b1) nticks++;
        end
        check("inc0_ch1_quiet_cycles_bad", bad, 0);
        check("inc0_ch0_tick_count", nticks, 25);
        check("inc0_ch0_locked", {31'd0, locked[0]}, 32'd1);

        // Rewrite ch1 with 1234: only ch1 loses lock, then regains it after 8 edges
        wr_en = 1'b1; wr_chan = 1'b1; wr_inc = 16'h1234;
        step();
        wr_en = 1'b0;
        check("w1234_locked", {30'd0, locked}, 32'd1);
        repeat (7) step();
        check("w1234_locked_edge7", {30'd0, locked}, 32'd1);
        step();
        check("w1234_locked_edge8", {30'd0, locked}, 32'd3);

        // Asynchronous reset mid-cycle clears outputs before the next edge
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_tick", {30'd0, tick}, 32'd0);
        check("async_reset_clk_out", {30'd0, clk_out}, 32'd0);
        check("async_reset_locked", {30'd0, locked}, 32'd0);
        check("async_reset_locked3", {29'd0, locked3}, 32'd0);
        step();
        reset = 1'b0;

        // After reset both channels are back at 4000; dut3 ignores a write to channel 3
        for (int k = 1; k <= 16; k++) begin
            if (k == 9) begin
                wr_en3 = 1'b1; wr_chan3 = 2'd3; wr_inc3 = 16'hFFFF;
            end
            step();
            wr_en3 = 1'b0;
            check($sformatf("postrst_tick_k%0d", k), {30'd0, tick},
                  (k % 4 == 0) ? 32'd3 : 32'd0);
            if (k == 2) check("postrst_clk_out_k2", {30'd0, clk_out}, 32'd3);
            if (k == 8) check("postrst_locked_k8", {30'd0, locked}, 32'd3);
            if (k >= 9) begin
                check($sformatf("oor_tick3_k%0d", k), {29'd0, tick3},
                      (k % 4 == 0) ? 32'd7 : 32'd0);
                check($sformatf("oor_locked3_k%0d", k), {29'd0, locked3}, 32'd7);
            end
        end

`ifdef PHASE_ALIGN_EN
        // Phase align: ch0=4000 ticks 4 edges after align, ch1=2000 ticks 8 edges after
        wr_en = 1'b1; wr_chan = 1'b0; wr_inc = 16'h4000;
        step();
        wr_chan = 1'b1; wr_inc = 16'h2000;
        step();
        wr_en = 1'b0;
        repeat (10) step();
        check("align_pre_locked", {30'd0, locked}, 32'd3);
        align = 1'b1;
        step();
        align = 1'b0;
        check("align_edge_tick", {30'd0, tick}, 32'd0);
        check("align_edge_locked", {30'd0, locked}, 32'd3);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("align_tick_%0d", i), {30'd0, tick},
                  {30'd0, (i == 8) ? 1'b1 : 1'b0, (i % 4 == 0) ? 1'b1 : 1'b0});
            check($sformatf("align_locked_%0d", i), {30'd0, locked}, 32'd3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
